// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters and the Register_File write-port arbiter.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface regfile_wb_arbiter_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
);
  logic              A_Valid_i;
  logic [ADDR_W-1:0] A_Register_i;
  logic [N-1:0]      A_Data_i;
  logic              A_Ready_o;
  logic              B_Valid_i;
  logic [ADDR_W-1:0] B_Register_i;
  logic [N-1:0]      B_Data_i;
  logic              B_Ready_o;
  logic              Init_Busy_o;
  logic [1:0]        Grant_o;
  logic              Reg_Write_o;
  logic [ADDR_W-1:0] Write_Register_o;
  logic [N-1:0]      Write_Data_o;

  modport slave (
    input  A_Valid_i, A_Register_i, A_Data_i,
    input  B_Valid_i, B_Register_i, B_Data_i,
    output A_Ready_o, B_Ready_o, Init_Busy_o, Grant_o,
    output Reg_Write_o, Write_Register_o, Write_Data_o
  );

  modport master (
    output A_Valid_i, A_Register_i, A_Data_i,
    output B_Valid_i, B_Register_i, B_Data_i,
    input  A_Ready_o, B_Ready_o, Init_Busy_o, Grant_o,
    input  Reg_Write_o, Write_Register_o, Write_Data_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single Register_File write port shared round-robin by ALU (A) and load (B) writeback,
// preceded by a post-reset zero-fill of registers 1..NUM_REGS-1.
module regfile_wb_arbiter #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int CNT_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

  typedef enum logic {INIT, ARB} state_t;
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] idx;
    logic [N-1:0]      data;
  } wb_req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [N-1:0]      data_q, data_d;
  logic [1:0]        grant_q, grant_d;

  wb_req_t [1:0] req;
  logic    [1:0] rdy;
  logic          win;

  assign req[0] = {wb.A_Valid_i, wb.A_Register_i, wb.A_Data_i};
  assign req[1] = {wb.B_Valid_i, wb.B_Register_i, wb.B_Data_i};

  // Contention goes to whichever requester did not win the last transfer.
  always_comb begin
    rdy = '0;
    if (state_q == ARB) begin
      if (req[0].vld && req[1].vld) rdy = last_b_q ? 2'b01 : 2'b10;
      else                          rdy = {req[1].vld, req[0].vld};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    wr_d     = 1'b0;
    idx_d    = idx_q;
    data_d   = data_q;
    grant_d  = '0;
    win      = rdy[1];
    case (state_q)
      INIT: begin
        wr_d   = 1'b1;
        idx_d  = ADDR_W'(cnt_q);
        data_d = '0;
        if (cnt_q == LAST_IDX) state_d = ARB;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ARB: begin
        if (|rdy) begin
          grant_d  = rdy;
          idx_d    = req[win].idx;
          data_d   = req[win].data;
          // register 0 is hardwired: handshake completes but the write is dropped
          wr_d     = |req[win].idx;
          last_b_d = win;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      cnt_q    <= CNT_W'(1);
      last_b_q <= 1'b1;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
    end
  end

  assign wb.A_Ready_o        = rdy[0];
  assign wb.B_Ready_o        = rdy[1];
  assign wb.Init_Busy_o      = (state_q == INIT);
  assign wb.Grant_o          = grant_q;
  assign wb.Reg_Write_o      = wr_q;
  assign wb.Write_Register_o = idx_q;
  assign wb.Write_Data_o     = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a transaction-level model
// (fill sequence, round-robin pick, register-file contents).
module tb_regfile_wb_arbiter;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N(N), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter #(.N(N), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Register_File stand-in written by the DUT, and the model's view of it
  logic [N-1:0] rf  [NR] = '{default: 32'hDEAD_BEEF};
  logic [N-1:0] mem [NR] = '{default: 32'hDEAD_BEEF};
  always @(posedge clk) if (bus.Reg_Write_o) rf[bus.Write_Register_o] <= bus.Write_Data_o;

  logic          av, bv;
  logic [AW-1:0] ar, br;
  logic [N-1:0]  ad, bd;

  bit            m_init, m_last_b, a_acc, b_acc;
  int            fill;
  logic          e_wr;
  logic [1:0]    e_grant;
  logic [AW-1:0] e_reg;
  logic [N-1:0]  e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; fill = 1; m_last_b = 1;
    e_wr = 0; e_grant = 0; e_reg = 0; e_data = 0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step();
    bus.A_Valid_i = av; bus.A_Register_i = ar; bus.A_Data_i = ad;
    bus.B_Valid_i = bv; bus.B_Register_i = br; bus.B_Data_i = bd;
    #1;
    if (e_wr) mem[e_reg] = e_data;
    a_acc = 0; b_acc = 0;
    if (m_init) begin
      e_wr = 1; e_grant = 0; e_reg = AW'(fill); e_data = 0;
      fill++;
      if (fill == NR) m_init = 0;
    end else begin
      a_acc   = av && (!bv || m_last_b);
      b_acc   = bv && !a_acc;
      e_wr    = 0;
      e_grant = {b_acc, a_acc};
      if (a_acc) begin
        e_reg = ar; e_data = ad; e_wr = (ar != 0); m_last_b = 0;
      end else if (b_acc) begin
        e_reg = br; e_data = bd; e_wr = (br != 0); m_last_b = 1;
      end
    end
    chk("a_ready", bus.A_Ready_o, a_acc);
    chk("b_ready", bus.B_Ready_o, b_acc);
    @(negedge clk);
    chk("reg_write", bus.Reg_Write_o, e_wr);
    chk("grant", bus.Grant_o, e_grant);
    chk("init_busy", bus.Init_Busy_o, m_init);
    if (e_wr) begin
      chk("write_reg", bus.Write_Register_o, e_reg);
      chk("write_data", bus.Write_Data_o, e_data);
    end
  endtask

  task automatic do_reset();
    bus.A_Valid_i = av; bus.B_Valid_i = bv;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_reg_write", bus.Reg_Write_o, 0);
    chk("rst_grant", bus.Grant_o, 0);
    chk("rst_write_reg", bus.Write_Register_o, 0);
    chk("rst_write_data", bus.Write_Data_o, 0);
    chk("rst_init_busy", bus.Init_Busy_o, 1);
    chk("rst_a_ready", bus.A_Ready_o, 0);
    chk("rst_b_ready", bus.B_Ready_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    av = 0; bv = 0; ar = 0; br = 0; ad = 0; bd = 0;
    do_reset();
    repeat (NR + 1) step();

    av = 1; ar = 2; ad = 7; step();
    av = 0; step();

    bv = 1; br = 9; bd = 5; step();
    bv = 0; step();

    av = 1; ar = 4; ad = 20; bv = 1; br = 25; bd = 6;
    repeat (4) step();
    av = 0; bv = 0; step();

    bv = 1; br = 0; bd = 3; step();
    bv = 0; step();

    av = 1; ar = 7; ad = 32'h1234; bv = 1; br = 7; bd = 32'h5678;
    repeat (2) step();
    av = 0; bv = 0; step();

    // reset mid-ARB, then again mid-fill
    do_reset();
    repeat (10) step();
    do_reset();

    av = 1; ar = 31; ad = 78;
    repeat (NR - 1) step();
    step();
    av = 0; step();

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step();
      if (!av || a_acc) begin
        av = ($urandom_range(0, 9) < 6);
        ar = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        ad = $urandom;
      end
      if (!bv || b_acc) begin
        bv = ($urandom_range(0, 9) < 6);
        br = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        bd = $urandom;
      end
    end
    av = 0; bv = 0;
    repeat (2) step();

    for (int i = 0; i < NR; i++) chk($sformatf("rf[%0d]", i), rf[i], mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
